ssd_scan_controller: RTL and testbench
======================================

Name: ssd_scan_controller

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one BCD/hex-to-segment decoder.
- Holds a multi-digit hex value and steps through the digits. For each digit it presents the nibble to the shared decoder and drives the matching active-low anode.
- Inserts a dead-time gap between digits to prevent ghosting.
- Double-buffers host updates so a new value only takes effect at a frame boundary, which keeps the display from tearing.

Parameters:
- DIGITS, 4: number of digits scanned; digit 0 is least significant.
- PRESCALE, 50000: clock cycles per digit slot (dead time plus active time).
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot. Legal range is 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- Clock     input   1          system clock, rising edge.
- Reset     input   1          asynchronous, active-high reset.
- Value     input   4*DIGITS   hex value to display; nibble i occupies bits [4i+3:4i].
- Load      input   1          one-cycle strobe; captures Value into the pending buffer.
- Enable    input   1          high = scanning; low = display dark.
- LzBlank   input   1          high = suppress leading zeros.
- Nibble    output  4          nibble for the current digit, fed to the shared decoder.
- Anode     output  DIGITS     digit enables, active-low.
- Blank     output  1          high = decoder output must be forced to all segments off.
- FrameDone output  1          one-cycle pulse on the last cycle of each frame.
- LoadAck   output  1          one-cycle pulse when the pending value is committed to the display.

Behaviour:
- Registers:
  - pend: the pending buffer.
  - pflag: set when pend holds an uncommitted value.
  - disp: the displayed value.
  - idx: digit index, 0..DIGITS-1.
  - cnt: slot counter, 0..PRESCALE-1.
  - state: IDLE, GAP or SHOW.
- Every output is registered. Outputs change only on the rising edge of Clock or on Reset.
- Reset (asynchronous, takes effect immediately, including mid-slot):
  - Anode = all ones, Blank = 1, Nibble = 0, FrameDone = 0, LoadAck = 0.
  - disp = 0, pend = 0, pflag = 0, idx = 0, cnt = 0, state = IDLE.
- IDLE:
  - Anode = all ones, Blank = 1.
  - When Enable is sampled high, go to GAP with idx = 0 and cnt = 0. This entry counts as a frame boundary.
- GAP:
  - Anode = all ones, Blank = 1, Nibble = disp[idx].
  - Lasts BLANK_CYCLES cycles, then go to SHOW.
- SHOW:
  - Anode[idx] = 0 and all other anode bits = 1; Blank = 0; Nibble = disp[idx].
  - Lasts PRESCALE - BLANK_CYCLES cycles.
  - Then go to GAP with idx + 1. After DIGITS-1 it wraps to 0, which is a frame boundary.
- Frame period is DIGITS*PRESCALE cycles. FrameDone is high on the final SHOW cycle of digit DIGITS-1.
- Frame boundary (the edge entering GAP with idx = 0):
  - If pflag is set: disp <= pend, pflag <= 0, and LoadAck is high for exactly the first GAP cycle.
  - If pflag is clear: no change and no LoadAck.
- Load:
  - Load sets pend <= Value and pflag <= 1. Multiple Loads within a frame: the last one wins, and only one LoadAck is issued.
  - A Load sampled on the same edge as a commit is not part of that commit. It stays pending (pflag remains 1) and is committed at the next frame boundary.
  - Load is accepted in every state, including IDLE.
- Leading-zero blanking:
  - Applies when LzBlank = 1 and i > 0.
  - Digit i is suppressed if disp nibbles DIGITS-1 down to i are all zero.
  - A suppressed digit's SHOW phase keeps Anode all ones and Blank = 1. Its timing is unchanged.
  - Digit 0 is never suppressed.
- Enable:
  - Enable sampled low in GAP or SHOW goes to IDLE on that edge. Outputs go dark and idx and cnt clear.
  - No FrameDone is issued for the aborted frame. pend and pflag are retained.
  - Re-enabling restarts at digit 0 with a commit check.

Test Plan:
(All scenarios use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.)
- Basic scan: Load=1 with Value=16'h1234, then Enable=1.
  - LoadAck pulses on the first GAP cycle.
  - Per digit: 2 cycles with Anode=4'b1111 and Blank=1, then 6 cycles with Anode equal to 1110, 1101, 1011, 0111 respectively and Nibble equal to 4, 3, 2, 1 respectively.
  - FrameDone pulses every 32 cycles.
- Double-buffering: during a frame showing 16'h1234, Load 16'hAAAA and then 16'hBBBB.
  - Nibble keeps showing 1234 until the boundary, then shows B.
  - Exactly one LoadAck is issued.
  - A Load on the exact commit edge appears one frame later.
- Leading zeros: Value=16'h0050 with LzBlank=1.
  - Digits 3 and 2 stay dark (Anode=1111, Blank=1 for the full slot); digit 1 shows 5; digit 0 shows 0.
  - Value=16'h0000: only digit 0 lights.
  - With LzBlank=0, all four digits light.
- Enable drop mid-SHOW of digit 2.
  - Next cycle: Anode=1111, Blank=1, no FrameDone.
  - Re-enable: scan restarts at digit 0 after a 2-cycle gap.
- Asynchronous reset mid-SHOW.
  - Immediately, without waiting for a clock edge: Anode=1111, Blank=1, Nibble=0.
  - After release with Enable=1: digit 0 shows 0, and no LoadAck is issued.

Source files
------------

// File: rtl/ssd_scan_controller_if.sv
// Host-side bundle for the seven-segment scan controller: value/strobe/control
// inputs and the registered drive signals for the shared decoder and anodes.
interface ssd_scan_controller_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                enable;
  logic                lz_blank;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   anode;
  logic                blank;
  logic                frame_done;
  logic                load_ack;

  modport master (
    output value, load, enable, lz_blank,
    input  nibble, anode, blank, frame_done, load_ack
  );

  modport slave (
    input  value, load, enable, lz_blank,
    output nibble, anode, blank, frame_done, load_ack
  );
endinterface

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed common-anode digit scanner with per-slot dead time,
// frame-boundary double buffering and optional leading-zero suppression.
module ssd_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_scan_controller_if.slave bus
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [4*DIGITS-1:0] disp, disp_n, pend;
  logic                pflag, commit;
  logic [DIGITS-1:0]   zero_top;
  logic                run, suppress;
  logic [3:0]          nibble_n;
  logic [DIGITS-1:0]   anode_n;
  logic                blank_n, frame_done_n, load_ack_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      disp           <= '0;
      pend           <= '0;
      pflag          <= 1'b0;
      bus.nibble     <= '0;
      bus.anode      <= '1;
      bus.blank      <= 1'b1;
      bus.frame_done <= 1'b0;
      bus.load_ack   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      disp  <= disp_n;
      // A load on the commit edge is captured after the old pend is consumed
      if (bus.load) begin
        pend  <= bus.value;
        pflag <= 1'b1;
      end else if (commit) begin
        pflag <= 1'b0;
      end
      bus.nibble     <= nibble_n;
      bus.anode      <= anode_n;
      bus.blank      <= blank_n;
      bus.frame_done <= frame_done_n;
      bus.load_ack   <= load_ack_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          state_n = GAP;
          idx_n   = '0;
          cnt_n   = '0;
          commit  = pflag;
        end
      end
      GAP: begin
        if (!bus.enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == GAP_LAST) state_n = SHOW;
        end
      end
      SHOW: begin
        if (!bus.enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n  = '0;
            commit = pflag;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase

    disp_n = commit ? pend : disp;

    // Outputs are derived from next-cycle state so the registers line up with it
    run      = 1'b1;
    zero_top = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run & (disp_n[4*(DIGITS-1-k) +: 4] == 4'h0);
      zero_top[DIGITS-1-k] = run;
    end
    suppress = bus.lz_blank && (idx_n != '0) && zero_top[idx_n];

    nibble_n = '0;
    anode_n  = '1;
    blank_n  = 1'b1;
    if (state_n != IDLE) nibble_n = disp_n[4*idx_n +: 4];
    if (state_n == SHOW && !suppress) begin
      anode_n = ~(DIGITS'(1) << idx_n);
      blank_n = 1'b0;
    end
    frame_done_n = (state_n == SHOW) && (idx_n == IDX_LAST) && (cnt_n == CNT_LAST);
    load_ack_n   = commit;
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller at DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_ssd_scan_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ssd_scan_controller_if #(.DIGITS(4)) bus ();

  ssd_scan_controller #(
    .DIGITS      (4),
    .PRESCALE    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_anode"}, -1, 16'(bus.anode), 16'hF);
    chk({tag, "_blank"}, -1, 16'(bus.blank), 16'h1);
    chk({tag, "_fdone"}, -1, 16'(bus.frame_done), 16'h0);
    chk({tag, "_ack"},   -1, 16'(bus.load_ack), 16'h0);
  endtask

  // Checks ncyc cycles of a frame starting at its first GAP cycle; `lit` marks
  // which digits are expected to light in their SHOW phase. Up to three loads
  // can be driven at given cycle numbers (-1 = unused).
  task automatic check_frame(input logic [15:0] shown, input logic [3:0] lit,
                             input logic ack_first, input int ncyc,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int lc, input logic [15:0] vc);
    int d, s;
    logic [3:0] exp_an;
    logic exp_bl;
    for (int c = 0; c < ncyc; c++) begin
      d = c / 8;
      s = c % 8;
      if (s < 2 || !lit[d]) begin
        exp_an = 4'hF;
        exp_bl = 1'b1;
      end else begin
        exp_an = ~(4'b0001 << d);
        exp_bl = 1'b0;
      end
      chk("anode",  c, 16'(bus.anode), 16'(exp_an));
      chk("blank",  c, 16'(bus.blank), 16'(exp_bl));
      chk("nibble", c, 16'(bus.nibble), 16'(shown[4*d +: 4]));
      chk("fdone",  c, 16'(bus.frame_done), 16'(c == 31));
      chk("ack",    c, 16'(bus.load_ack), 16'(c == 0 && ack_first));
      bus.load = 1'b0;
      if (c == la) begin bus.load = 1'b1; bus.value = va; end
      if (c == lb) begin bus.load = 1'b1; bus.value = vb; end
      if (c == lc) begin bus.load = 1'b1; bus.value = vc; end
      step();
    end
    bus.load = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.enable   = 1'b0;
    bus.lz_blank = 1'b0;
    step();
    chk_dark("rst");
    chk("rst_nibble", -1, 16'(bus.nibble), 16'h0);

    // Basic scan
    rst       = 1'b0;
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    step();
    chk_dark("idle_load");
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    step();
    check_frame(16'h1234, 4'hF, 1'b1, 32, -1, '0, -1, '0, -1, '0);

    // Double buffering: last load wins, load on commit edge lands a frame later
    check_frame(16'h1234, 4'hF, 1'b0, 32, 3, 16'h5555, 10, 16'hAAAA, 31, 16'hBBBB);
    check_frame(16'hAAAA, 4'hF, 1'b1, 32, -1, '0, -1, '0, -1, '0);
    check_frame(16'hBBBB, 4'hF, 1'b1, 32, -1, '0, -1, '0, -1, '0);
    check_frame(16'hBBBB, 4'hF, 1'b0, 32, 10, 16'h0050, -1, '0, -1, '0);

    // Leading-zero suppression
    bus.lz_blank = 1'b1;
    check_frame(16'h0050, 4'b0011, 1'b1, 32, 10, 16'h0000, -1, '0, -1, '0);
    check_frame(16'h0000, 4'b0001, 1'b1, 32, -1, '0, -1, '0, -1, '0);
    bus.lz_blank = 1'b0;
    check_frame(16'h0000, 4'hF, 1'b0, 32, 10, 16'h0500, -1, '0, -1, '0);
    bus.lz_blank = 1'b1;
    check_frame(16'h0500, 4'b0111, 1'b1, 32, -1, '0, -1, '0, -1, '0);
    bus.lz_blank = 1'b0;

    // Enable drop in SHOW of digit 2, load while idle, then restart
    check_frame(16'h0500, 4'hF, 1'b0, 21, -1, '0, -1, '0, -1, '0);
    chk("drop_pre_anode", -1, 16'(bus.anode), 16'hB);
    bus.enable = 1'b0;
    step();
    chk_dark("drop1");
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    step();
    chk_dark("drop2");
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    step();
    check_frame(16'h1234, 4'hF, 1'b1, 32, -1, '0, -1, '0, -1, '0);

    // Asynchronous reset in SHOW of digit 1 with a load pending
    check_frame(16'h1234, 4'hF, 1'b0, 12, 5, 16'h9999, -1, '0, -1, '0);
    chk("pre_rst_anode", -1, 16'(bus.anode), 16'hD);
    #2;
    rst = 1'b1;
    #1;
    chk_dark("async_rst");
    chk("async_rst_nibble", -1, 16'(bus.nibble), 16'h0);
    #2;
    rst = 1'b0;
    step();
    check_frame(16'h0000, 4'hF, 1'b0, 32, -1, '0, -1, '0, -1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
